alu_arbiter: RTL

Shares one 8-bit combinational ALU (3-bit op select; ops are ADD, SUB, AND, OR, PASS-A, SHL-A, SHR-A, ZERO) between two requesters.
Each requester issues one operation with a valid/ready handshake. The block arbitrates round-robin, drives the ALU from registered operands, captures the result, and returns it on that requester's response channel.
The block sits between the core's issue logic and the ALU instance. The ALU stays outside and connects through the alu_* ports.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/rr_arb2.sv | 17 +
 rtl/alu_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: op codes, FSM states, default widths.
package alu_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int OP_W_DEF   = 3;
   localparam int CNT_W_DEF  = 16;

   localparam logic [2:0] ALU_ADD  = 3'd0;
   localparam logic [2:0] ALU_SUB  = 3'd1;
   localparam logic [2:0] ALU_AND  = 3'd2;
   localparam logic [2:0] ALU_OR   = 3'd3;
   localparam logic [2:0] ALU_PASS = 3'd4;
   localparam logic [2:0] ALU_SHL  = 3'd5;
   localparam logic [2:0] ALU_SHR  = 3'd6;
   localparam logic [2:0] ALU_ZERO = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the port
// that did not win last time.
module rr_arb2 (
   input  logic valid0,
   input  logic valid1,
   input  logic last_grant,
   output logic gnt_valid,
   output logic gnt_idx
);

   // Pick the winner from the current requests and the previous grant.
   always_comb begin
      gnt_valid = valid0 | valid1;
      gnt_idx   = (valid0 & valid1) ? ~last_grant : valid1;
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters. One
// operation at a time: accept (IDLE), drive the ALU from registered operands
// (EXEC), then hold the registered result on the winner's response channel
// (RESP) until it is taken.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int OP_W   = OP_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [OP_W-1:0]   req0_op,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic [DATA_W-1:0] rsp0_data,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [OP_W-1:0]   req1_op,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DATA_W-1:0] rsp1_data,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [OP_W-1:0]   alu_sel,
   input  logic [DATA_W-1:0] alu_out,
   output logic              busy,
   output logic [CNT_W-1:0]  ops_done
);

   state_t              state_reg, state_next;
   logic                last_grant_reg;
   logic                gnt_reg;
   logic [OP_W-1:0]     op_reg;
   logic [DATA_W-1:0]   a_reg, b_reg, result_reg;
   logic [CNT_W-1:0]    ops_done_reg;

   logic [1:0]          req_valid_vec, req_ready_vec;
   logic [1:0]          rsp_ready_vec, rsp_valid_vec;
   logic [OP_W-1:0]     req_op_arr [2];
   logic [DATA_W-1:0]   req_a_arr [2];
   logic [DATA_W-1:0]   req_b_arr [2];
   logic [DATA_W-1:0]   rsp_data_arr [2];
   logic                gnt_valid, gnt_idx;
   logic                rsp_take;

   // Gather the two port sets into indexable vectors.
   assign req_valid_vec = {req1_valid, req0_valid};
   assign rsp_ready_vec = {rsp1_ready, rsp0_ready};
   assign req_op_arr[0] = req0_op;
   assign req_op_arr[1] = req1_op;
   assign req_a_arr[0]  = req0_a;
   assign req_a_arr[1]  = req1_a;
   assign req_b_arr[0]  = req0_b;
   assign req_b_arr[1]  = req1_b;

   rr_arb2 u_arb (
      .valid0     (req0_valid),
      .valid1     (req1_valid),
      .last_grant (last_grant_reg),
      .gnt_valid  (gnt_valid),
      .gnt_idx    (gnt_idx)
   );

   // Response is consumed only when the granted port's ready is seen in RESP.
   assign rsp_take = (state_reg == RESP) && rsp_ready_vec[gnt_reg];

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // Next-state logic: each operation spends at least one cycle per state.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (gnt_valid) state_next = EXEC;
         EXEC:    state_next = RESP;
         RESP:    if (rsp_take) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath registers: latch the accepted request, capture the ALU result,
   // and update fairness/count only when the response is actually taken.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant_reg <= 1'b1;
         gnt_reg        <= 1'b0;
         op_reg         <= '0;
         a_reg          <= '0;
         b_reg          <= '0;
         result_reg     <= '0;
         ops_done_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: if (gnt_valid) begin
               gnt_reg <= gnt_idx;
               op_reg  <= req_op_arr[gnt_idx];
               a_reg   <= req_a_arr[gnt_idx];
               b_reg   <= req_b_arr[gnt_idx];
            end
            EXEC: result_reg <= alu_out;
            RESP: if (rsp_take) begin
               ops_done_reg   <= ops_done_reg + CNT_W'(1);
               last_grant_reg <= gnt_reg;
            end
            default: ;
         endcase
      end
   end

   // Outputs: ready only for the winner in IDLE, ALU inputs only in EXEC.
   always_comb begin
      req_ready_vec = 2'b00;
      alu_a         = '0;
      alu_b         = '0;
      alu_sel       = '0;
      if (state_reg == IDLE && gnt_valid) req_ready_vec[gnt_idx] = 1'b1;
      if (state_reg == EXEC) begin
         alu_a   = a_reg;
         alu_b   = b_reg;
         alu_sel = op_reg;
      end
   end

   // Per-port response channels; the idle port shows zero data.
   for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
      assign rsp_valid_vec[gi] = (state_reg == RESP) && (gnt_reg == 1'(gi));
      assign rsp_data_arr[gi]  = rsp_valid_vec[gi] ? result_reg : '0;
   end

   assign req0_ready = req_ready_vec[0];
   assign req1_ready = req_ready_vec[1];
   assign rsp0_valid = rsp_valid_vec[0];
   assign rsp1_valid = rsp_valid_vec[1];
   assign rsp0_data  = rsp_data_arr[0];
   assign rsp1_data  = rsp_data_arr[1];
   assign busy       = (state_reg != IDLE);
   assign ops_done   = ops_done_reg;

endmodule
